// File: rtl/alu_unit.sv
// Execute-stage ALU: single-cycle add/sub/logic/shift plus an optional shift-add multiply.
// Define ALU_MUL_EN to build the multiplier; otherwise op 7 completes at once and raises error.
module alu_unit #(
   parameter int DATA_BUS_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [2:0]                alu_op,
   input  logic [DATA_BUS_WIDTH-1:0] operand_a,
   input  logic [DATA_BUS_WIDTH-1:0] operand_b,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_BUS_WIDTH-1:0] result,
   output logic                      flag_zero,
   output logic                      flag_carry,
   output logic                      flag_neg,
   output logic                      error
);

   localparam int W  = DATA_BUS_WIDTH;
   localparam int SW = $clog2(W);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

   state_t         state_reg;
   logic [2:0]     op_reg;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic           busy_reg;
   logic           done_reg;
   logic [W-1:0]   result_reg;
   logic           zero_reg;
   logic           carry_reg;
   logic           neg_reg;
   logic           error_reg;

`ifdef ALU_MUL_EN
   logic [2*W-1:0] acc_reg;
   logic [2*W-1:0] mcand_reg;
   logic [W-1:0]   mplier_reg;
   logic [SW-1:0]  cnt_reg;
`endif

   logic           accept;
   logic [W-1:0]   res_next;
   logic           carry_next;
   logic           err_next;
   logic [W:0]     wide_next;
   logic [SW-1:0]  amt;

   // A new op may be taken in IDLE or in the DONE cycle, giving back-to-back issue.
   assign accept = start && (state_reg != S_MULT);
   assign amt    = b_reg[SW-1:0];

   always_comb begin
      res_next   = '0;
      carry_next = 1'b0;
      err_next   = 1'b0;
      wide_next  = '0;
      case (op_reg)
         OP_ADD: begin
            wide_next  = {1'b0, a_reg} + {1'b0, b_reg};
            res_next   = wide_next[W-1:0];
            carry_next = wide_next[W];
         end
         OP_SUB: begin
            wide_next  = {1'b0, a_reg} - {1'b0, b_reg};
            res_next   = wide_next[W-1:0];
            carry_next = wide_next[W];
         end
         OP_AND: res_next = a_reg & b_reg;
         OP_OR:  res_next = a_reg | b_reg;
         OP_XOR: res_next = a_reg ^ b_reg;
         OP_SHL: begin
            // Extra guard bit catches the last bit shifted out; stays 0 for amount 0.
            wide_next  = {1'b0, a_reg} << amt;
            res_next   = wide_next[W-1:0];
            carry_next = wide_next[W];
         end
         OP_SHR: begin
            wide_next  = {a_reg, 1'b0} >> amt;
            res_next   = wide_next[W:1];
            carry_next = wide_next[0];
         end
         OP_MUL: begin
`ifdef ALU_MUL_EN
            res_next   = acc_reg[W-1:0];
            carry_next = |acc_reg[2*W-1:W];
`else
            err_next   = 1'b1;
`endif
         end
         default: err_next = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
         neg_reg    <= 1'b0;
         error_reg  <= 1'b0;
`ifdef ALU_MUL_EN
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_DONE: begin
               result_reg <= res_next;
               zero_reg   <= (res_next == '0);
               carry_reg  <= carry_next;
               neg_reg    <= res_next[W-1];
               error_reg  <= err_next;
               done_reg   <= 1'b1;
               state_reg  <= S_IDLE;
            end
`ifdef ALU_MUL_EN
            S_MULT: begin
               if (mplier_reg[0]) begin
                  acc_reg <= acc_reg + mcand_reg;
               end
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + 1'b1;
               if (cnt_reg == SW'(W - 1)) begin
                  state_reg <= S_DONE;
                  busy_reg  <= 1'b0;
               end
            end
`endif
            S_IDLE:  state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase

         if (accept) begin
            op_reg    <= alu_op;
            a_reg     <= operand_a;
            b_reg     <= operand_b;
            state_reg <= S_DONE;
`ifdef ALU_MUL_EN
            if (alu_op == OP_MUL) begin
               state_reg  <= S_MULT;
               busy_reg   <= 1'b1;
               acc_reg    <= '0;
               mcand_reg  <= {{W{1'b0}}, operand_a};
               mplier_reg <= operand_b;
               cnt_reg    <= '0;
            end
`endif
         end
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign result     = result_reg;
   assign flag_zero  = zero_reg;
   assign flag_carry = carry_reg;
   assign flag_neg   = neg_reg;
   assign error      = error_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus random ops against an arithmetic model.
module tb_alu_unit;

   localparam int W = 8;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clock;
   logic         reset;
   logic         start;
   logic [2:0]   alu_op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         flag_zero;
   logic         flag_carry;
   logic         flag_neg;
   logic         error;

   int checks = 0;
   int errors = 0;

   alu_unit #(.DATA_BUS_WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .alu_op     (alu_op),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_neg   (flag_neg),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operation definitions.
   task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic c, output logic e);
      int ai, bi, amt, v;
      ai = int'(a);
      bi = int'(b);
      amt = bi % W;
      r = 8'd0;
      c = 1'b0;
      e = 1'b0;
      case (op)
         3'd0: begin v = ai + bi; r = 8'(v % 256); c = (v > 255); end
         3'd1: begin v = ai - bi + 256; r = 8'(v % 256); c = (ai < bi); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin
            r = 8'((ai * (1 << amt)) % 256);
            c = (amt != 0) ? (((ai >> (W - amt)) % 2) == 1) : 1'b0;
         end
         3'd6: begin
            r = 8'(ai >> amt);
            c = (amt != 0) ? (((ai >> (amt - 1)) % 2) == 1) : 1'b0;
         end
         default: begin
            if (MUL_EN) begin
               v = ai * bi;
               r = 8'(v % 256);
               c = (v > 255);
            end else begin
               e = 1'b1;
            end
         end
      endcase
   endtask

   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] er;
      logic       ec, ee, is_mul;
      int         cycles, busy_cycles, exp_cycles, exp_busy;
      model(op, a, b, er, ec, ee);
      is_mul     = MUL_EN && (op == 3'd7);
      exp_cycles = is_mul ? W + 2 : 2;
      exp_busy   = is_mul ? W : 0;
      @(negedge clock);
      start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
      @(negedge clock);
      start = 1'b0;
      alu_op = 3'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
      cycles = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         if (busy === 1'b1) busy_cycles++;
         // Junk requests while busy must be ignored; never drive start into the DONE cycle.
         if (busy === 1'b1 && cycles < W) begin
            start = 1'($urandom_range(0, 1));
            alu_op = 3'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         cycles++;
      end
      start = 1'b0;
      check("latency", 32'(cycles), 32'(exp_cycles));
      check("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
      check("result", 32'(result), 32'(er));
      check("flag_carry", 32'(flag_carry), 32'(ec));
      check("flag_zero", 32'(flag_zero), 32'(er == 8'd0));
      check("flag_neg", 32'(flag_neg), 32'(er[7]));
      check("error", 32'(error), 32'(ee));
      $display("op=%0d a=%02h b=%02h -> result=%02h z=%0b c=%0b n=%0b err=%0b cycles=%0d",
               op, a, b, result, flag_zero, flag_carry, flag_neg, error, cycles);
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(er));
   endtask

   initial begin
      bit saw_done;
      reset = 1'b0; start = 1'b0; alu_op = 3'd0; operand_a = '0; operand_b = '0;
      repeat (2) @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({flag_zero, flag_carry, flag_neg, error}), 32'd0);
      reset = 1'b1;

      // Reset asserted between accept and completion aborts the op asynchronously.
      do_op(3'd4, 8'hFF, 8'h0F);
      @(negedge clock);
      start = 1'b1; alu_op = 3'd1; operand_a = 8'h10; operand_b = 8'h20;
      @(negedge clock);
      start = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_rst_result", 32'(result), 32'd0);
      check("async_rst_flags", 32'({flag_zero, flag_carry, flag_neg, error}), 32'd0);
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("rst_no_done", 32'(saw_done), 32'd0);
      reset = 1'b1;

      do_op(3'd0, 8'h7F, 8'h01);
      do_op(3'd0, 8'hFF, 8'h01);
      do_op(3'd1, 8'h03, 8'h05);
      do_op(3'd1, 8'h05, 8'h05);
      do_op(3'd5, 8'h81, 8'h01);
      do_op(3'd6, 8'h81, 8'h09);
      do_op(3'd5, 8'h5A, 8'h08);
      do_op(3'd6, 8'h5A, 8'h10);
      do_op(3'd5, 8'h01, 8'h07);
      do_op(3'd6, 8'h80, 8'h07);

      do_op(3'd7, 8'h0C, 8'h0B);
      if (MUL_EN) begin
         @(negedge clock);
         start = 1'b1; alu_op = 3'd7; operand_a = 8'hFF; operand_b = 8'hFF;
         @(negedge clock);
         start = 1'b0;
         repeat (3) @(negedge clock);
         #2 reset = 1'b0;
         #1;
         check("mul_rst_busy", 32'(busy), 32'd0);
         check("mul_rst_result", 32'(result), 32'd0);
         saw_done = 1'b0;
         repeat (W + 3) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1'b1;
         end
         check("mul_rst_no_done", 32'(saw_done), 32'd0);
         reset = 1'b1;
         do_op(3'd0, 8'h01, 8'h01);
      end
      do_op(3'd7, 8'h10, 8'h10);
      do_op(3'd0, 8'h01, 8'h01);

      // Start held across the DONE cycle issues a second op immediately.
      @(negedge clock);
      start = 1'b1; alu_op = 3'd2; operand_a = 8'hF0; operand_b = 8'h3C;
      @(negedge clock);
      alu_op = 3'd3; operand_a = 8'hF0; operand_b = 8'h0F;
      check("b2b_wait", 32'(done), 32'd0);
      @(negedge clock);
      start = 1'b0;
      check("b2b_and_done", 32'(done), 32'd1);
      check("b2b_and_result", 32'(result), 32'h30);
      @(negedge clock);
      check("b2b_or_done", 32'(done), 32'd1);
      check("b2b_or_result", 32'(result), 32'hFF);
      check("b2b_or_neg", 32'(flag_neg), 32'd1);
      @(negedge clock);
      check("b2b_done_drop", 32'(done), 32'd0);

      for (int i = 0; i < 30; i++) begin
         do_op(3'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
